// File: rtl/data_line.sv
// data_line: one cache line of BYTES bytes with a word-wide CPU port and a
// beat-wise line-fill port.
//
// Optional feature: define DATA_PARITY_EN to keep one even-parity bit per
// stored byte and flag read-back parity errors on rd_perr. Without it, no
// parity is stored and rd_perr is tied low.
//
// Parameters
//   BYTES      bytes per line (power of two, >= WORD_BYTES)
//   WORD_BYTES bytes per access word (power of two, 1..8)
//   INIT       value loaded into every byte on reset
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   cpu_we      word write request (honoured only while idle)
//   cpu_rd      word read request (honoured only while idle)
//   cpu_idx     word index within the line
//   cpu_be      per-byte write enables
//   cpu_wdata   write data
//   cpu_rdata   read data, one cycle after the request; holds otherwise
//   cpu_rvalid  read data valid pulse
//   fill_start  begin a line fill (sampled only while idle)
//   fill_valid  fill beat valid
//   fill_data   fill beat data, beat k lands in word k
//   fill_ready  high while a fill is accepting beats
//   fill_done   one-cycle pulse once the last beat has been written
//   busy        fill in progress or completing
//   dirty       line modified by the CPU since the last completed fill
//   rd_perr     parity error on the returned word, alongside cpu_rvalid
module data_line #(
  parameter int unsigned BYTES      = 16,
  parameter int unsigned WORD_BYTES = 4,
  parameter logic [7:0]  INIT       = 8'h00,
  localparam int unsigned WORDS     = BYTES / WORD_BYTES,
  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int unsigned W         = 8 * WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_we,
  input  logic                  cpu_rd,
  input  logic [IDX_W-1:0]      cpu_idx,
  input  logic [WORD_BYTES-1:0] cpu_be,
  input  logic [W-1:0]          cpu_wdata,
  output logic [W-1:0]          cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  fill_start,
  input  logic                  fill_valid,
  input  logic [W-1:0]          fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  output logic                  busy,
  output logic                  dirty,
  output logic                  rd_perr
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                    state, state_nx;
  logic [IDX_W-1:0]          cnt, cnt_nx;
  logic [WORDS-1:0][W-1:0]   line;

  logic beat;
  logic last_beat;
  logic wr_en;
  logic rd_en;

  assign busy      = (state != IDLE);
  assign beat      = (state == FILL) && fill_valid;
  assign last_beat = (cnt == IDX_W'(WORDS - 1));
  // A fill request takes priority over a same-cycle write; reads still go.
  assign wr_en     = (state == IDLE) && cpu_we && !fill_start;
  assign rd_en     = (state == IDLE) && cpu_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    fill_ready = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nx = FILL;
          cnt_nx   = '0;
        end
      end
      FILL: begin
        fill_ready = 1'b1;
        if (fill_valid) begin
          if (last_beat) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + IDX_W'(1);
          end
        end
      end
      DONE: begin
        fill_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line <= {(WORDS * WORD_BYTES){INIT}};
    end else if (beat) begin
      line[cnt] <= fill_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (cpu_be[i]) line[cpu_idx][8*i +: 8] <= cpu_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty <= 1'b0;
    end else if (state == DONE) begin
      dirty <= 1'b0;
    end else if (wr_en && (|cpu_be)) begin
      dirty <= 1'b1;
    end
  end

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= rd_en;
      if (rd_en) cpu_rdata <= line[cpu_idx];
    end
  end

`ifdef DATA_PARITY_EN
  logic [WORDS-1:0][WORD_BYTES-1:0] par;
  logic [WORD_BYTES-1:0]            byte_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par <= {(WORDS * WORD_BYTES){^INIT}};
    end else if (beat) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        par[cnt][i] <= ^fill_data[8*i +: 8];
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (cpu_be[i]) par[cpu_idx][i] <= ^cpu_wdata[8*i +: 8];
      end
    end
  end

  // Even parity: byte bits plus stored bit must XOR to zero.
  always_comb begin
    byte_err = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      byte_err[i] = ^{line[cpu_idx][8*i +: 8], par[cpu_idx][i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_perr <= 1'b0;
    end else begin
      rd_perr <= rd_en && (|byte_err);
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: doc/data_line.md
DATA_LINE -- requirements
Module: data_line

Interface
REQ-001 SHALL have parameter BYTES, default 16, bytes per cache line (power of two, >= WORD_BYTES).
REQ-002 SHALL have parameter WORD_BYTES, default 4, bytes per access word (power of two, 1..8).
REQ-003 SHALL have parameter INIT, default 8'h00, value loaded into every byte on reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports cpu_we / cpu_rd  input  1 each  word write / word read request.
REQ-007 SHALL have port cpu_idx  input  log2(BYTES/WORD_BYTES) (min 1)  word index in line.
REQ-008 SHALL have ports cpu_be  input  WORD_BYTES  byte enables, and cpu_wdata  input  8*WORD_BYTES  write data.
REQ-009 SHALL have ports cpu_rdata  output  8*WORD_BYTES  read data, and cpu_rvalid  output  1  read data valid.
REQ-010 SHALL have ports fill_start  input  1  begin line fill, fill_valid  input  1  beat valid, fill_data  input  8*WORD_BYTES  beat data.
REQ-011 SHALL have ports fill_ready  output  1, fill_done  output  1, busy  output  1, dirty  output  1, rd_perr  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, DONE; busy = (state != IDLE).
REQ-013 IDLE: fill_start=1 -> FILL, beat counter cleared to 0; fill_start ignored outside IDLE.
REQ-014 FILL: fill_ready=1; beat accepted when fill_valid&fill_ready; beat k writes all bytes of word k; counter increments by 1.
REQ-015 Acceptance of beat BYTES/WORD_BYTES-1 -> DONE; counter wraps to 0; no further beats accepted.
REQ-016 DONE: fill_done=1 for exactly one cycle, dirty cleared, -> IDLE next cycle.
REQ-017 IDLE write: cpu_we=1 writes byte i of word cpu_idx from cpu_wdata[8i+7:8i] where cpu_be[i]=1; others unchanged.
REQ-018 dirty SHALL set on the cycle after an IDLE write with any cpu_be bit set; cpu_be=0 write is a no-op.
REQ-019 IDLE read: cpu_rd=1 -> cpu_rdata = word cpu_idx and cpu_rvalid=1 on next cycle (latency 1); otherwise cpu_rvalid=0, cpu_rdata holds.
REQ-020 Same-cycle read and write to same word SHALL return pre-write data (read-before-write).
REQ-021 cpu_we and cpu_rd while busy SHALL be dropped: no state change, no rvalid.
REQ-022 fill_start with cpu_we in same IDLE cycle: fill wins, write dropped; with cpu_rd: read served.
REQ-023 fill_valid outside FILL SHALL be ignored.

Reset
REQ-024 reset low SHALL immediately force: all bytes = INIT, state IDLE, counter 0, dirty 0, cpu_rvalid 0, cpu_rdata 0, fill_done 0, rd_perr 0.
REQ-025 reset mid-fill SHALL abandon the fill; no fill_done is produced.

Configuration
REQ-026 With DATA_PARITY_EN defined, SHALL store one even-parity bit per byte, written with the byte, and set rd_perr with cpu_rvalid when any returned enabled-word byte fails parity.
REQ-027 Without DATA_PARITY_EN, SHALL store no parity and tie rd_perr to 0.

Verification
REQ-028 Reset with INIT=8'hA5, BYTES=16, WORD_BYTES=4; read idx 2 -> next cycle cpu_rvalid=1, cpu_rdata=32'hA5A5A5A5, dirty=0.
REQ-029 Write idx 1 be=4'b0101 data 32'h11223344 over INIT 8'h00 -> read idx 1 returns 32'h00220044, dirty=1.
REQ-030 fill_start then 4 beats 32'h0,1,2,3 with fill_valid deasserted one cycle between beats 1 and 2 -> fill_done pulses once after beat 3, dirty=0, reads idx 0..3 return 0..3.
REQ-031 cpu_we/cpu_rd during FILL -> no cpu_rvalid, line contents match fill data only.
REQ-032 reset asserted after 2 fill beats -> all words INIT, busy=0, no fill_done.
REQ-033 With DATA_PARITY_EN, force a stored data bit flip in bench, read that word -> rd_perr=1 with cpu_rvalid; unaffected word -> rd_perr=0.
